// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks the (i, j, k) loop nest of an NxN matrix multiply.
// Each cycle it issues one operand-RAM read. The MAC enable/clear and the
// result-RAM write strobes follow one and two cycles behind that read.
// Optional busy-cycle counter: define MATMUL_SEQ_PERF_EN to build it.
module matmul_sequencer #(
    parameter int MAX_SIZE = 10,
    parameter int ADDR_W   = $clog2(MAX_SIZE * MAX_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        size,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              acc_en,
    output logic              acc_clr,
    output logic              r_we,
    output logic [ADDR_W-1:0] r_addr,
    output logic [15:0]       perf_cycles
);

    localparam int CNT_W = $clog2(MAX_SIZE + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d, i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ADDR_W-1:0]  ibase_q, ibase_d, kbase_q, kbase_d;
    logic               drain_q, drain_d, err_q, err_d;
    logic               size_ok, start_ok, k_last, j_last, i_last, kill;

    // Pipeline tags that travel with each issued (i, j, k)
    logic               vld_p1, clr_p1, last_p1, we_p2;
    logic [ADDR_W-1:0]  raddr_p1, raddr_p2;

    assign size_ok  = ({24'd0, size} >= 32'd2) && ({24'd0, size} <= 32'(MAX_SIZE));
    assign start_ok = (state_q == S_IDLE) && start && size_ok;
    assign k_last   = (k_q == n_q - CNT_W'(1));
    assign j_last   = (j_q == n_q - CNT_W'(1));
    assign i_last   = (i_q == n_q - CNT_W'(1));
    assign kill     = abort && ((state_q == S_RUN) || (state_q == S_DRAIN));

    assign rd_en    = (state_q == S_RUN);
    assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    // Addresses come from row bases plus an offset; no multiplier is involved
    assign a_addr   = rd_en ? ibase_q + ADDR_W'(k_q) : '0;
    assign b_addr   = rd_en ? kbase_q + ADDR_W'(j_q) : '0;
    assign acc_en   = vld_p1;
    assign acc_clr  = vld_p1 && clr_p1;
    assign r_we     = we_p2;
    assign r_addr   = raddr_p2;

    // Next-state and loop-counter logic: k innermost, then j, then i
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        ibase_d = ibase_q;
        kbase_d = kbase_q;
        drain_d = drain_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (size_ok) begin
                        state_d = S_RUN;
                        n_d     = size[CNT_W-1:0];
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        ibase_d = '0;
                        kbase_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (k_last) begin
                    k_d     = '0;
                    kbase_d = '0;
                    if (j_last) begin
                        j_d = '0;
                        if (i_last) begin
                            i_d     = '0;
                            ibase_d = '0;
                            drain_d = 1'b0;
                            state_d = S_DRAIN;
                        end else begin
                            i_d     = i_q + CNT_W'(1);
                            ibase_d = ibase_q + ADDR_W'(n_q);
                        end
                    end else begin
                        j_d = j_q + CNT_W'(1);
                    end
                end else begin
                    k_d     = k_q + CNT_W'(1);
                    kbase_d = kbase_q + ADDR_W'(n_q);
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (drain_q) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, size and loop-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            ibase_q <= '0;
            kbase_q <= '0;
            drain_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            ibase_q <= ibase_d;
            kbase_q <= kbase_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    // Issue -> stage 1 (accumulate) -> stage 2 (write); abort squashes in-flight strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            clr_p1   <= 1'b0;
            last_p1  <= 1'b0;
            raddr_p1 <= '0;
            we_p2    <= 1'b0;
            raddr_p2 <= '0;
        end else begin
            vld_p1   <= rd_en && !kill;
            clr_p1   <= (k_q == '0);
            last_p1  <= k_last;
            raddr_p1 <= ibase_q + ADDR_W'(j_q);
            we_p2    <= vld_p1 && last_p1 && !kill;
            raddr_p2 <= raddr_p1;
        end
    end

`ifdef MATMUL_SEQ_PERF_EN
    logic [15:0] perf_q;

    // Busy-cycle counter: cleared by an accepted start, saturates, holds when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (start_ok) begin
            perf_q <= '0;
        end else if (busy && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign perf_cycles     = '0;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: the driver pushes the expected event
// schedule of every request, and a negedge monitor pops and compares it.
module tb_matmul_sequencer;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    size = 8'd0;
    logic          abort = 1'b0;
    logic          busy, done, err, rd_en, acc_en, acc_clr, r_we;
    logic [AW-1:0] a_addr, b_addr, r_addr;
    logic [15:0]   perf_cycles;

    matmul_sequencer #(.MAX_SIZE(10), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .size(size), .abort(abort),
        .busy(busy), .done(done), .err(err), .rd_en(rd_en),
        .a_addr(a_addr), .b_addr(b_addr), .acc_en(acc_en), .acc_clr(acc_clr),
        .r_we(r_we), .r_addr(r_addr), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct { int cyc; int v0; int v1; } ev_t;
    ev_t q_rd[$], q_acc[$], q_wr[$], q_done[$], q_err[$];
    int busy_lo = 1;
    int busy_hi = 0;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int perf_exp(input int busy_cycles);
`ifdef MATMUL_SEQ_PERF_EN
        return busy_cycles;
`else
        return 0 * busy_cycles;
`endif
    endfunction

    // Reference schedule from the loop-nest definition; abort_at==0 means run to completion
    task automatic plan(input int n, input int abort_at);
        int base, n3, i, j, k, c;
        base = cyc;
        n3 = n * n * n;
        for (int t = 0; t < n3; t++) begin
            i = t / (n * n);
            j = (t / n) % n;
            k = t % n;
            c = 1 + t;
            if (abort_at == 0 || c <= abort_at)
                q_rd.push_back('{base + c, i * n + k, k * n + j});
            if (abort_at == 0 || c + 1 <= abort_at)
                q_acc.push_back('{base + c + 1, (k == 0) ? 1 : 0, 0});
            if (k == n - 1 && (abort_at == 0 || c + 2 <= abort_at))
                q_wr.push_back('{base + c + 2, i * n + j, 0});
        end
        busy_lo = base + 1;
        busy_hi = base + ((abort_at != 0) ? abort_at : n3 + 2);
        if (abort_at == 0)
            q_done.push_back('{base + n3 + 3, perf_exp(n3 + 2), 0});
    endtask

    task automatic leftover(input string name);
        chk(name, q_rd.size() + q_acc.size() + q_wr.size() + q_done.size() + q_err.size(), 0);
    endtask

    // One multiply; optional abort at a cycle, optional noise on start/size while busy
    task automatic run_mat(input int n, input int abort_at, input bit noise);
        int n3, last;
        n3 = n * n * n;
        plan(n, abort_at);
        start = 1'b1;
        size  = 8'(n);
        last  = (abort_at != 0) ? abort_at + 2 : n3 + 4;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            start = (noise && c <= n3 + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            size  = 8'($urandom);
            abort = (c == abort_at);
        end
        #1;
        leftover("run_leftover");
        chk("perf_hold", int'(perf_cycles), perf_exp((abort_at != 0) ? abort_at : n3 + 2));
    endtask

    task automatic bad_size(input int s);
        q_err.push_back('{cyc + 1, 0, 0});
        start = 1'b1;
        size  = 8'(s);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        leftover("err_leftover");
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            start = 1'b0;
            size  = 8'($urandom);
            abort = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, int'({busy, done, err, rd_en, acc_en, acc_clr, r_we}), 0);
        chk({name, "_addr"}, int'({a_addr, b_addr, r_addr}), 0);
        chk({name, "_perf"}, int'(perf_cycles), 0);
    endtask

    // Monitor: compares every strobe against the head of its expectation queue
    always @(negedge clk) begin
        if (rst_n) begin
            ev_t e;
            chk("busy", int'(busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
            if (acc_clr && !acc_en) chk("acc_clr_alone", 1, 0);
            if (rd_en) begin
                if (q_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    e = q_rd.pop_front();
                    chk("rd_cyc", cyc, e.cyc);
                    chk("a_addr", int'(a_addr), e.v0);
                    chk("b_addr", int'(b_addr), e.v1);
                end
            end
            if (acc_en) begin
                if (q_acc.size() == 0) chk("acc_unexpected", 1, 0);
                else begin
                    e = q_acc.pop_front();
                    chk("acc_cyc", cyc, e.cyc);
                    chk("acc_clr", int'(acc_clr), e.v0);
                end
            end
            if (r_we) begin
                if (q_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    e = q_wr.pop_front();
                    chk("wr_cyc", cyc, e.cyc);
                    chk("r_addr", int'(r_addr), e.v0);
                end
            end
            if (done) begin
                if (q_done.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    e = q_done.pop_front();
                    chk("done_cyc", cyc, e.cyc);
                    chk("done_perf", int'(perf_cycles), e.v0);
                end
            end
            if (err) begin
                if (q_err.size() == 0) chk("err_unexpected", 1, 0);
                else begin
                    e = q_err.pop_front();
                    chk("err_cyc", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int n, ab;
        #3 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        run_mat(2, 0, 0);
        run_mat(3, 0, 0);
        bad_size(1);
        bad_size(0);
        bad_size(11);
        bad_size(255);
        run_mat(3, 5, 0);
        run_mat(3, 0, 1);
        run_mat(10, 0, 0);
        idle(4);
        run_mat(2, 0, 1);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(2, 10);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n * n * n + 2) : 0;
            run_mat(n, ab, (ab == 0));
            if ($urandom_range(0, 2) == 0) bad_size($urandom_range(11, 255));
            idle($urandom_range(0, 5));
        end

        // Reset in the middle of a run: everything clears at once, nothing follows
        plan(4, 0);
        start = 1'b1;
        size  = 8'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        q_rd.delete(); q_acc.delete(); q_wr.delete(); q_done.delete(); q_err.delete();
        busy_lo = 1;
        busy_hi = 0;
        rst_n = 1'b0;
        #1 chk_all_zero("midrun_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        #1 leftover("post_reset_leftover");
        run_mat(2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
